// File: rtl/hawk_axi_rd_rspdr.sv
// ---------------------------------------------------------------------------
// hawk_axi_rd_rspdr
//
// AXI read-channel responder in front of a single-port SRAM with one cycle
// of read latency. It accepts one INCR burst at a time on the AR channel and
// fetches one SRAM word per beat. It returns the beats on the R channel.
// Beats whose word address falls outside the SRAM window are answered with
// SLVERR and zero data. The burst always delivers arlen+1 beats.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   rd_reqpkt  : addr, arlen, arvalid, rready from the read initiator
//   rd_rdypkt  : arready back to the initiator
//   rd_resppkt : rvalid, rlast, rdata, rresp back to the initiator
//   mem_req    : SRAM read strobe (one-cycle pulse)
//   mem_idx    : SRAM word index for the strobe
//   mem_rdata  : SRAM read data, valid the cycle after mem_req
//   busy       : high whenever a burst is in progress
//
// The packet structs live in hawk_axi_rd_pkg below. Their data/address
// widths are fixed there, so DATA_W and ADDR_W on the module must match
// AXI_DATA_W and AXI_ADDR_W.
// ---------------------------------------------------------------------------

package hawk_axi_rd_pkg;

  localparam int unsigned AXI_DATA_W = 512;
  localparam int unsigned AXI_ADDR_W = 64;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic                  rvalid;
    logic                  rlast;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
  } axi_rd_resppkt_t;

endpackage

module hawk_axi_rd_rspdr
  import hawk_axi_rd_pkg::*;
#(
  parameter int unsigned       DATA_W    = AXI_DATA_W,
  parameter int unsigned       ADDR_W    = AXI_ADDR_W,
  parameter int unsigned       MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  axi_rd_reqpkt_t               rd_reqpkt,
  output axi_rd_rdypkt_t               rd_rdypkt,
  output axi_rd_resppkt_t              rd_resppkt,
  output logic                         mem_req,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_idx,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned WORD_W = ADDR_W - OFF_W;

  localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(MEM_DEPTH);
  localparam logic [WORD_W-1:0] WORD_ONE    = WORD_W'(1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_WAIT,
    RESP,
    ERR_RESP
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   word_q;
  logic [7:0]          arlen_q;
  logic [7:0]          beat_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic                mem_req_q;
  logic [IDX_W-1:0]    mem_idx_q;

  logic [ADDR_W:0]     addr_diff;
  logic                addr_below_base;
  logic [WORD_W-1:0]   req_word;
  logic                req_in_range;
  logic [WORD_W-1:0]   next_word;
  logic                next_in_range;
  logic [7:0]          next_beat;
  logic                ar_hs;
  logic                r_hs;

  // The extra top bit of addr_diff is the borrow. It flags addresses below
  // the SRAM window without a separate magnitude compare. The word offset is
  // taken from the difference, so the byte-offset bits drop out naturally.
  assign addr_diff       = {1'b0, rd_reqpkt.addr} - {1'b0, BASE_ADDR};
  assign addr_below_base = addr_diff[ADDR_W];
  assign req_word        = WORD_W'(addr_diff[ADDR_W-1:0] >> OFF_W);
  assign req_in_range    = !addr_below_base && (req_word < DEPTH_WORDS);

  // Bursts only advance from RESP, where word_q is known to be inside the
  // window, so next_word cannot overflow. Running off the top of the SRAM is
  // an error, never a wrap back to word 0.
  assign next_word     = word_q + WORD_ONE;
  assign next_in_range = next_word < DEPTH_WORDS;
  assign next_beat     = beat_q + 8'd1;

  assign ar_hs = (state_q == IDLE) && rd_reqpkt.arvalid;
  assign r_hs  = rvalid_q && rd_reqpkt.rready;

  // Main controller: AR capture, SRAM fetch sequencing and R beat delivery.
  // Every outward-facing signal is a flop so nothing combinational leaks
  // onto the AXI or SRAM side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      word_q    <= '0;
      arlen_q   <= '0;
      beat_q    <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      mem_req_q <= 1'b0;
      mem_idx_q <= '0;
    end else begin
      // mem_req is a single-cycle strobe; it is only raised on the edge
      // that enters MEM_RD.
      mem_req_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (ar_hs) begin
            arlen_q <= rd_reqpkt.arlen;
            beat_q  <= '0;
            word_q  <= req_word;
            if (req_in_range) begin
              state_q   <= MEM_RD;
              mem_req_q <= 1'b1;
              mem_idx_q <= req_word[IDX_W-1:0];
            end else begin
              state_q  <= ERR_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
              rlast_q  <= (rd_reqpkt.arlen == 8'd0);
            end
          end
        end

        MEM_RD: begin
          state_q <= MEM_WAIT;
        end

        MEM_WAIT: begin
          rdata_q  <= mem_rdata;
          rresp_q  <= RESP_OKAY;
          rvalid_q <= 1'b1;
          rlast_q  <= (beat_q == arlen_q);
          state_q  <= RESP;
        end

        RESP: begin
          if (r_hs) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              beat_q <= next_beat;
              word_q <= next_word;
              if (next_in_range) begin
                state_q   <= MEM_RD;
                mem_req_q <= 1'b1;
                mem_idx_q <= next_word[IDX_W-1:0];
              end else begin
                // The burst has walked off the end of the SRAM. Every
                // remaining beat is answered as an error from here on.
                state_q  <= ERR_RESP;
                rvalid_q <= 1'b1;
                rresp_q  <= RESP_SLVERR;
                rdata_q  <= '0;
                rlast_q  <= (next_beat == arlen_q);
              end
            end
          end
        end

        ERR_RESP: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              rresp_q  <= RESP_OKAY;
              state_q  <= IDLE;
            end else begin
              beat_q  <= next_beat;
              rlast_q <= (next_beat == arlen_q);
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // arready and busy are decoded straight from the state register. That
  // gives arready the cycle after the last R handshake and drops it on the
  // edge that captures a request.
  assign rd_rdypkt.arready = (state_q == IDLE);
  assign busy              = (state_q != IDLE);

  assign rd_resppkt.rvalid = rvalid_q;
  assign rd_resppkt.rlast  = rlast_q;
  assign rd_resppkt.rdata  = rdata_q;
  assign rd_resppkt.rresp  = rresp_q;

  assign mem_req = mem_req_q;
  assign mem_idx = mem_idx_q;

endmodule

// File: doc/hawk_axi_rd_rspdr.md
HAWK_AXI_RD_RSPDR -- requirements
Module: hawk_axi_rd_rspdr

Interface
REQ-001 SHALL have parameter DATA_W, default 512: AXI read data width in bits; also the SRAM word width.
REQ-002 SHALL have parameter ADDR_W, default 64: AXI address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: SRAM words, power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of SRAM word 0, aligned to DATA_W/8.
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port rd_reqpkt, input, struct axi_rd_reqpkt_t: addr, arlen[7:0], arvalid, rready from the read initiator.
REQ-008 SHALL have port rd_rdypkt, output, struct axi_rd_rdypkt_t: arready.
REQ-009 SHALL have port rd_resppkt, output, struct axi_rd_resppkt_t: rvalid, rlast, rdata[DATA_W], rresp[2].
REQ-010 SHALL have port mem_req, output, 1: SRAM read strobe.
REQ-011 SHALL have port mem_idx, output, clog2(MEM_DEPTH): SRAM word index.
REQ-012 SHALL have port mem_rdata, input, DATA_W: SRAM data, valid exactly 1 cycle after mem_req.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, MEM_RD, MEM_WAIT, RESP, ERR_RESP.
REQ-015 SHALL drive arready=1 only in IDLE; an AR handshake is arvalid&&arready in the same cycle.
REQ-016 On an AR handshake SHALL capture addr, arlen and clear the beat counter; at most one outstanding burst.
REQ-017 SHALL ignore addr bits below log2(DATA_W/8).
REQ-018 SHALL compute idx = (addr-BASE_ADDR)>>log2(DATA_W/8); in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH*DATA_W/8.
REQ-019 IDLE->MEM_RD on a handshake with an in-range address; IDLE->ERR_RESP on a handshake with an out-of-range address.
REQ-020 MEM_RD SHALL pulse mem_req=1 for one cycle with mem_idx=idx, then go to MEM_WAIT.
REQ-021 MEM_WAIT SHALL register mem_rdata into rdata, set rresp=2'b00, then go to RESP.
REQ-022 Latency: handshake in cycle N -> mem_req in N+1 -> rvalid first high in N+3.
REQ-023 RESP SHALL hold rvalid=1 and rdata, rresp, rlast stable until rready=1.
REQ-024 rlast SHALL be 1 iff beat counter == captured arlen.
REQ-025 On an R handshake with rlast=1 SHALL go to IDLE; arready rises the following cycle.
REQ-026 On an R handshake with rlast=0 SHALL increment the beat counter and the word address by 1 (INCR burst).
REQ-027 After REQ-026, if the next address is in range SHALL go to MEM_RD; otherwise SHALL go to ERR_RESP. There is no wrap-around past the last SRAM word.
REQ-028 ERR_RESP SHALL drive rvalid=1, rresp=2'b10 (SLVERR), rdata=0, rlast per REQ-024, and mem_req=0.
REQ-029 ERR_RESP SHALL follow the same rready and beat rules as RESP and stay in ERR_RESP for the remaining beats, so the beat count always equals arlen+1.
REQ-030 arlen=0 SHALL produce exactly one beat with rlast=1; arlen=255 SHALL produce 256 beats.
REQ-031 SHALL assert mem_req only in MEM_RD, never while rvalid=1.
REQ-032 rvalid SHALL never drop before its R handshake; arvalid arriving while busy SHALL be ignored until IDLE.

Reset
REQ-033 On rst_ni=0, asynchronously: state=IDLE, arready=1, rvalid=0, rlast=0, rdata=0, rresp=0, mem_req=0, mem_idx=0, busy=0, beat counter=0, captured addr/arlen=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further beats; the initiator reissues after reset.

Verification
REQ-035 Single beat: SRAM[3]=A5..A5, AR addr=BASE+3*64, arlen=0, rready=1 -> one beat in N+3 with rdata=A5..A5, rresp=0, rlast=1; arready=1 at N+4.
REQ-036 Burst with backpressure: SRAM[0..3]=0..3, AR addr=BASE, arlen=3, rready toggling 1/0 -> beats 0,1,2,3 in order, rlast only on beat 3, each beat held stable while rready=0.
REQ-037 Out of range: AR addr=BASE+MEM_DEPTH*64, arlen=1 -> 2 beats with rresp=2'b10, rdata=0, no mem_req pulse.
REQ-038 Range straddle: AR at the last word, arlen=2 -> beat0 OKAY with SRAM[MEM_DEPTH-1], beats 1 and 2 SLVERR, rlast on beat 2.
REQ-039 Reset mid-burst: assert rst_ni=0 during beat 1 of an arlen=3 burst -> rvalid=0 and arready=1 immediately; the next AR is served normally.
REQ-040 arvalid held high during a burst -> no second capture until IDLE; a back-to-back AR is accepted the cycle after rlast.
